// File: rtl/adder_seq.sv
// Byte-serial adder/subtractor: one 8-bit adder reused once per byte of the operands.
// Latency: oValid rises NBYTES cycles after the accepting edge.
// Backpressure: accepts only in IDLE; result held in DONE until iReady.
module adder_seq #(
    parameter int NBYTES = 4
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iValid,
    output logic                oReady,
    input  logic [8*NBYTES-1:0] iData_a,
    input  logic [8*NBYTES-1:0] iData_b,
    input  logic                iC,
    input  logic                iSub,
    output logic                oValid,
    input  logic                iReady,
    output logic [8*NBYTES-1:0] oData,
    output logic                oData_c,
    output logic                oOvf
);
    localparam int W  = 8 * NBYTES;
    localparam int KW = $clog2(NBYTES + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;      // already inverted for subtract
    logic          r_carry;
    logic [KW-1:0] r_k;
    logic [W-1:0]  r_data;
    logic          r_c;
    logic          r_ovf;

    logic [7:0]    w_a_byte;
    logic [7:0]    w_b_byte;
    logic [8:0]    w_sum;
    logic          w_last;
    logic          w_accept;

    // Reset holds the block in IDLE, so ready is advertised but nothing is taken.
    assign oReady   = iRst | (r_state == S_IDLE);
    assign oValid   = (r_state == S_DONE);
    assign w_accept = iValid & (r_state == S_IDLE) & ~iRst;
    assign w_last   = (r_k == K_LAST);

    // Select byte k of each latched operand for the shared adder.
    always_comb begin
        w_a_byte = '0;
        w_b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_k == KW'(i)) begin
                w_a_byte = r_a[i*8 +: 8];
                w_b_byte = r_b[i*8 +: 8];
            end
        end
    end

    // The only adder in the block: 8 bits plus carry-in.
    assign w_sum = {1'b0, w_a_byte} + {1'b0, w_b_byte} + {8'd0, r_carry};

    // Control FSM and byte-serial datapath state.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_data  <= '0;
            r_c     <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= iData_a;
                        r_b     <= iSub ? ~iData_b : iData_b;
                        r_carry <= iSub ? 1'b1 : iC;
                        r_k     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (r_k == KW'(i)) begin
                            r_data[i*8 +: 8] <= w_sum[7:0];
                        end
                    end
                    r_carry <= w_sum[8];
                    if (w_last) begin
                        // Top byte: its sum bit 7 is the result MSB.
                        r_c     <= w_sum[8];
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) & (w_sum[7] != r_a[W-1]);
                        r_k     <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (iReady) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oData   = r_data;
    assign oData_c = r_c;
    assign oOvf    = r_ovf;
endmodule

// File: doc/adder_seq.md
ADDER_SEQ -- requirements
Module: adder_seq

Interface
REQ-001 Parameter: NBYTES, default 4, operand width in bytes; legal range 1..16; the data width W is 8*NBYTES.
REQ-002 iClk  input  1  clock; all state changes on the rising edge.
REQ-003 iRst  input  1  reset; synchronous and active-high.
REQ-004 iValid  input  1  request valid.
REQ-005 oReady  output  1  request accepted when iValid & oReady at a rising edge.
REQ-006 iData_a  input  W  operand A.
REQ-007 iData_b  input  W  operand B.
REQ-008 iC  input  1  carry-in for add; ignored when iSub=1.
REQ-009 iSub  input  1  0 = A+B+iC; 1 = A-B, computed as A+~B+1.
REQ-010 oValid  output  1  result valid.
REQ-011 iReady  input  1  result consumed when oValid & iReady at a rising edge.
REQ-012 oData  output  W  result.
REQ-013 oData_c  output  1  carry-out of the MSB; for subtract, 1 = no borrow.
REQ-014 oOvf  output  1  two's-complement signed overflow.

Function
REQ-015 The block SHALL contain exactly one 8-bit add datapath (a+b+cin -> 8-bit sum plus carry) and reuse it once per byte; no W-bit adder.
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
  - oReady=1 only in IDLE.
  - oValid=1 only in DONE.
REQ-017 IDLE, on accept:
  - latch A;
  - latch B' = iSub ? ~B : B;
  - set the carry register to iSub ? 1 : iC;
  - clear byte index k to 0;
  - go to RUN.
REQ-018 RUN, each cycle:
  - add byte k of A, byte k of B' and the carry register;
  - write the sum into byte k of the result register;
  - load the carry-out into the carry register;
  - k <= k+1.
REQ-019 RUN, when k = NBYTES-1:
  - after the byte write, go to DONE;
  - set oData_c to the final carry-out;
  - set oOvf = (A[W-1]==B'[W-1]) & (sum[W-1]!=A[W-1]).
REQ-020 Latency: oValid SHALL rise exactly NBYTES cycles after the accepting edge. For NBYTES=1: accept, one RUN cycle, then DONE.
REQ-021 DONE:
  - oData, oData_c and oOvf SHALL remain stable until iReady=1;
  - on iReady=1, go to IDLE the next cycle.
REQ-022 iValid in RUN or DONE SHALL be ignored; operands are not sampled and no request is queued.
REQ-023 iValid=1 while DONE & iReady=1 SHALL NOT be accepted that cycle; it is accepted in the following IDLE cycle if still asserted. Minimum spacing between accepts is NBYTES+2 cycles.
REQ-024 Input operands SHALL be sampled only at the accepting edge; changes to them during RUN or DONE SHALL NOT affect the result.
REQ-025 In IDLE, oData/oData_c/oOvf SHALL hold the last result; during RUN their values are unspecified and not checked.
REQ-026 Index k SHALL be ceil(log2(NBYTES+1)) bits wide and SHALL never exceed NBYTES-1 in RUN.

Reset
REQ-027 With iRst=1 at a rising edge, the next cycle SHALL have:
  - state=IDLE;
  - oReady=1 and oValid=0;
  - oData=0, oData_c=0, oOvf=0;
  - carry register and k cleared.
REQ-028 Reset SHALL take priority over accept, RUN progress and iReady. An operation in flight is aborted and produces no oValid.
REQ-029 During iRst=1, oReady SHALL be 1 but no request SHALL be accepted.

Verification (NBYTES=4)
REQ-030 Reset: hold iRst 2 cycles -> oReady=1, oValid=0, oData=0x00000000, oData_c=0, oOvf=0.
REQ-031 Add with carry and latency: A=0x000000FF, B=0x00000001, iC=1, iSub=0 -> oData=0x00000101, oData_c=0, oOvf=0; oValid exactly 4 cycles after the accepting edge.
REQ-032 Add boundaries:
  - A=0xFFFFFFFF, B=0x00000001, iC=0 -> 0x00000000, oData_c=1, oOvf=0;
  - A=0x7FFFFFFF, B=0x00000001 -> 0x80000000, oData_c=0, oOvf=1.
REQ-033 Subtract:
  - A=0x00000005, B=0x00000007, iSub=1, iC=1 (ignored) -> 0xFFFFFFFE, oData_c=0, oOvf=0;
  - A=0x80000000, B=0x00000001, iSub=1 -> 0x7FFFFFFF, oData_c=1, oOvf=1.
REQ-034 Backpressure: hold iReady=0 for 3 cycles in DONE while driving iValid=1 with new operands -> outputs stable, oReady=0, nothing accepted; then iReady=1 -> IDLE next cycle and the pending iValid is accepted one cycle later.
REQ-035 Mid-operation reset: assert iRst when k=2 -> IDLE next cycle, oValid never rises, oData=0; a following A=0x00010000 + B=0x00010000 -> 0x00020000.
